// File: rtl/stopwatch_timer.sv
// stopwatch_timer: dual-mode countdown timer / count-up stopwatch
// with lap hold, button edge detection and registered display outputs.
module stopwatch_timer #(
  parameter int MIN_W         = 6,
  parameter int MAX_MIN       = 59,
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             mode,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             lap,
  input  logic             inc_min,
  input  logic             inc_sec,
  input  logic             inc,
  output logic [MIN_W-1:0] minutes,
  output logic [5:0]       seconds,
  output logic             running,
  output logic             blink,
  output logic             lap_active
);

  localparam int SUB_W =
    (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);
  localparam logic [SUB_W-1:0] SUB_ONE  = SUB_W'(1);
  localparam logic [MIN_W-1:0] MIN_TOP  = MIN_W'(MAX_MIN);
  localparam logic [MIN_W-1:0] MIN_ONE  = MIN_W'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_PAUSED = 2'd2;
  localparam logic [1:0] S_EXP    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             mode_q, mode_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  logic             lap_q, lap_d;
  logic [MIN_W-1:0] snap_min_q, snap_min_d;
  logic [5:0]       snap_sec_q, snap_sec_d;

  // Buttons ordered by priority, highest in the MSB.
  logic [5:0] btn, btn_q, ev;
  logic ev_clr, ev_stop, ev_start, ev_lap, ev_imin, ev_isec;
  logic adj_ok, lap_ok;

  assign btn      = {clear, stop, start, lap, inc_min, inc_sec};
  assign ev       = btn & ~btn_q;
  assign ev_clr   = ev[5];
  assign ev_stop  = ev[4] & ~ev[5];
  assign ev_start = ev[3] & ~|ev[5:4];
  assign ev_lap   = ev[2] & ~|ev[5:3];
  assign ev_imin  = ev[1] & ~|ev[5:2];
  assign ev_isec  = ev[0] & ~|ev[5:1];

  assign adj_ok = (state_q == S_IDLE) || (state_q == S_PAUSED);
  assign lap_ok = mode_q &&
                  ((state_q == S_RUN) || (state_q == S_PAUSED));

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    sub_d      = sub_q;
    min_d      = min_q;
    sec_d      = sec_q;
    lap_d      = lap_q;
    snap_min_d = snap_min_q;
    snap_sec_d = snap_sec_q;
    unique case (1'b1)
      ev_clr: begin
        min_d   = '0;
        sec_d   = '0;
        sub_d   = '0;
        lap_d   = 1'b0;
        state_d = S_IDLE;
      end
      ev_stop: begin
        if (state_q == S_RUN) state_d = S_PAUSED;
        else if (state_q == S_EXP) state_d = S_IDLE;
      end
      ev_start: begin
        if (state_q == S_IDLE) begin
          mode_d = mode;
          sub_d  = '0;
          if (mode || (min_q != '0) || (sec_q != '0))
            state_d = S_RUN;
        end else if (state_q == S_PAUSED) begin
          state_d = S_RUN;
        end else if (state_q == S_EXP) begin
          state_d = S_IDLE;
        end
      end
      ev_lap: begin
        if (lap_ok) begin
          lap_d = ~lap_q;
          if (!lap_q) begin
            snap_min_d = min_q;
            snap_sec_d = sec_q;
          end
        end
      end
      ev_imin: begin
        if (adj_ok) begin
          if (inc) min_d = (min_q == MIN_TOP) ? '0 : min_q + MIN_ONE;
          else     min_d = (min_q == '0) ? MIN_TOP : min_q - MIN_ONE;
        end
      end
      ev_isec: begin
        if (adj_ok) begin
          if (inc) sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
          else     sec_d = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
        end
      end
      default: ;
    endcase

    if ((state_q == S_RUN) && tick && !ev_clr && !ev_stop) begin
      if (sub_q != SUB_LAST) begin
        sub_d = sub_q + SUB_ONE;
      end else begin
        sub_d = '0;
        // Expiry drops any lap hold so the final count is what shows.
        if (mode_q) begin
          if (sec_q != 6'd59) begin
            sec_d = sec_q + 6'd1;
          end else if (min_q != MIN_TOP) begin
            sec_d = 6'd0;
            min_d = min_q + MIN_ONE;
          end else begin
            state_d = S_EXP;
            lap_d   = 1'b0;
          end
        end else begin
          if ((min_q == '0) && (sec_q <= 6'd1)) begin
            sec_d   = 6'd0;
            state_d = S_EXP;
            lap_d   = 1'b0;
          end else if (sec_q == 6'd0) begin
            sec_d = 6'd59;
            min_d = min_q - MIN_ONE;
          end else begin
            sec_d = sec_q - 6'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      sub_q      <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      lap_q      <= 1'b0;
      snap_min_q <= '0;
      snap_sec_q <= '0;
      btn_q      <= '0;
      minutes    <= '0;
      seconds    <= '0;
      running    <= 1'b0;
      blink      <= 1'b0;
      lap_active <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      sub_q      <= sub_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      lap_q      <= lap_d;
      snap_min_q <= snap_min_d;
      snap_sec_q <= snap_sec_d;
      btn_q      <= btn;
      minutes    <= lap_d ? snap_min_d : min_d;
      seconds    <= lap_d ? snap_sec_d : sec_d;
      running    <= (state_d == S_RUN);
      blink      <= (state_d == S_EXP);
      lap_active <= lap_d;
    end
  end

endmodule
